// File: rtl/miner_pkg.sv
// Shared definitions for the nonce scheduler: FSM encoding, step count and
// block phase constants.
package miner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    localparam int unsigned STEP_LAST_DEFAULT = 65;

    localparam logic [1:0] BLK_HDR0 = 2'd0;
    localparam logic [1:0] BLK_HDR1 = 2'd1;
    localparam logic [1:0] BLK_LAST = 2'd3;

endpackage

// File: rtl/hit_prio.sv
// Compares each core's h1 word against the target; lowest-index hit wins.
module hit_prio #(
    parameter int unsigned NUM_CORES = 4
) (
    input  logic [NUM_CORES*32-1:0] h1,
    input  logic [31:0]             target,
    output logic                    hit,
    output logic [3:0]              idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (!hit && (h1[32*k +: 32] < target)) begin
                hit = 1'b1;
                idx = 4'(k);
            end
        end
    end

endmodule

// File: rtl/nonce_sched.sv
// Nonce search scheduler: sequences block/select for the hash cores, feeds
// per-core message words, and evaluates core results once per full pass.
module nonce_sched
    import miner_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned NONCE_W    = 32,
    parameter int unsigned STEP_LAST  = STEP_LAST_DEFAULT,
    parameter int unsigned NONCE_WORD = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NONCE_W-1:0]      nonce_init,
    input  logic [31:0]             target,
    output logic [4:0]              msg_addr,
    input  logic [31:0]             msg_data,
    output logic [1:0]              block,
    output logic [6:0]              select,
    output logic [NUM_CORES*32-1:0] core_msg,
    input  logic [NUM_CORES*32-1:0] core_h1,
    output logic                    found_valid,
    input  logic                    found_ready,
    output logic [NONCE_W-1:0]      found_nonce,
    output logic [3:0]              found_core,
    output logic                    busy,
    output logic                    exhausted
);

    sched_state_t state, state_nx;

    logic [NONCE_W-1:0]      nonce_base;
    logic [NONCE_W:0]        base_sum;
    logic                    pass_valid;
    logic                    wrap_pend;
    logic                    hit;
    logic [3:0]              hit_core;
    logic                    eval;
    logic                    pass_end;
    logic                    advance;
    logic [NUM_CORES*32-1:0] msg_nx;

    hit_prio #(.NUM_CORES(NUM_CORES)) u_hit_prio (
        .h1     (core_h1),
        .target (target),
        .hit    (hit),
        .idx    (hit_core)
    );

    assign eval      = (state == ST_RUN) && pass_valid && (block == BLK_HDR0) && (select == '0);
    assign pass_end  = (state == ST_RUN) && (block == BLK_LAST) && (select == 7'(STEP_LAST));
    // A hit or a pending wrap keeps the counters parked at block 0 / select 0.
    assign advance   = (state == ST_RUN) && !(eval && (hit || wrap_pend));
    assign base_sum  = {1'b0, nonce_base} + (NONCE_W+1)'(NUM_CORES);
    assign msg_addr  = {block == BLK_HDR1, select[3:0]};
    assign busy      = (state == ST_RUN) || (state == ST_HOLD);
    assign exhausted = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (eval && hit)            state_nx = ST_HOLD;
                else if (eval && wrap_pend) state_nx = ST_DONE;
            end
            ST_HOLD: begin
                if (found_ready) state_nx = wrap_pend ? ST_DONE : ST_RUN;
            end
            default: state_nx = state;
        endcase
        if (start) state_nx = ST_RUN;
        if (stop)  state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block  <= '0;
            select <= '0;
        end else if (start || stop) begin
            block  <= '0;
            select <= '0;
        end else if (advance) begin
            if (select == 7'(STEP_LAST)) begin
                select <= '0;
                block  <= block + 2'd1;
            end else begin
                select <= select + 7'd1;
            end
        end else if (state != ST_HOLD) begin
            block  <= '0;
            select <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_base  <= '0;
            pass_valid  <= 1'b0;
            wrap_pend   <= 1'b0;
            found_valid <= 1'b0;
            found_nonce <= '0;
            found_core  <= '0;
        end else if (stop) begin
            pass_valid  <= 1'b0;
            wrap_pend   <= 1'b0;
            found_valid <= 1'b0;
        end else if (start) begin
            nonce_base  <= nonce_init;
            pass_valid  <= 1'b0;
            wrap_pend   <= 1'b0;
            found_valid <= 1'b0;
        end else begin
            if (eval) begin
                pass_valid <= 1'b0;
                // nonce_base has already moved on; the evaluated pass used the previous one.
                if (hit) begin
                    found_valid <= 1'b1;
                    found_nonce <= nonce_base - NONCE_W'(NUM_CORES) + NONCE_W'(hit_core);
                    found_core  <= hit_core;
                end
            end
            if (pass_end) begin
                nonce_base <= base_sum[NONCE_W-1:0];
                pass_valid <= 1'b1;
                if (base_sum[NONCE_W]) wrap_pend <= 1'b1;
            end
            if ((state == ST_HOLD) && found_ready) found_valid <= 1'b0;
        end
    end

    always_comb begin
        msg_nx = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (block == BLK_HDR0) begin
                msg_nx[32*k +: 32] = msg_data;
            end else if (block == BLK_HDR1) begin
                if (select == 7'(NONCE_WORD)) msg_nx[32*k +: 32] = 32'(nonce_base + NONCE_W'(k));
                else                          msg_nx[32*k +: 32] = msg_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  core_msg <= '0;
        else if (state == ST_RUN)    core_msg <= msg_nx;
        else if (state != ST_HOLD)   core_msg <= '0;
    end

endmodule
